// File: rtl/mul_share_pkg.sv
// Shared types and default sizing for the time-shared multiplier sequencer.
package mul_share_pkg;

  localparam int N_REQ_DEF   = 4;   // requesters sharing the multiplier
  localparam int W_DEF       = 6;   // signed operand width
  localparam int PW_DEF      = 11;  // product width from the multiplier
  localparam int MUL_LAT_DEF = 7;   // edges from operand launch to valid product

  // Counter must be able to hold MUL_LAT itself.
  localparam int CNT_W = $clog2(MUL_LAT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for a requester vector; never zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_seq_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr
// (wrapping) wins. Produces a one-hot grant plus the binary index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from lowest priority to highest so the highest-priority hit is the
  // last assignment and wins without needing a loop break.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (req[j]) begin
          idx = IW'(j);
          any = 1'b1;
        end
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_seq.sv
// Time-shares one signed multiplier between N_REQ requesters. One operation
// is in flight at a time: operands are held on mul_a/mul_b for the whole
// multiplier latency, the product is captured, and returned to its owner.
module mul_share_seq
  import mul_share_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int PW      = PW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0][W-1:0]   req_a,
  input  logic [N_REQ-1:0][W-1:0]   req_b,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [PW-1:0]             rsp_p,
  output logic [W-1:0]              mul_a,
  output logic [W-1:0]              mul_b,
  output logic                      mul_en,
  input  logic [PW-1:0]             mul_p,
  output logic                      busy
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(MUL_LAT + 1);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;

  // Arbitration is only live in IDLE, so req_ready can never fire while an
  // operation owns the multiplier.
  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (state == IDLE),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;

  // Sequencer: launch on grant, count out the latency, capture, then hold the
  // response until its owner accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_p     <= '0;
      rsp_valid <= '0;
      mul_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            mul_a  <= req_a[gnt_idx];
            mul_b  <= req_b[gnt_idx];
            owner  <= gnt_idx;
            rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt    <= '0;
            mul_en <= 1'b1;
            busy   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          // mul_p is only trustworthy once MUL_LAT edges have passed since
          // launch; cnt reaches MUL_LAT exactly on that edge's far side.
          if (cnt == CW'(MUL_LAT)) begin
            rsp_p     <= mul_p;
            rsp_valid <= N_REQ'(1) << owner;
            mul_en    <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // Only the owner's rsp_ready matters; others are ignored.
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          mul_en    <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_seq.sv
// Bench for mul_share_seq: a latency-honest multiplier model, a transaction
// level reference (round-robin pick, fixed response timing, signed product),
// a table of directed operations, hand-built corner sequences and random traffic.
module tb_mul_share_seq;

  localparam int N   = 4;
  localparam int W   = 6;
  localparam int PW  = 11;
  localparam int LAT = 7;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_a;
  logic [N-1:0][W-1:0]   req_b;
  logic [N-1:0]          rsp_valid;
  logic [N-1:0]          rsp_ready;
  logic [PW-1:0]         rsp_p;
  logic [W-1:0]          mul_a;
  logic [W-1:0]          mul_b;
  logic                  mul_en;
  logic [PW-1:0]         mul_p;
  logic                  busy;

  always #5 clk = ~clk;

  mul_share_seq #(.N_REQ(N), .W(W), .PW(PW), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  // Multiplier model: the product only appears once operands have been held
  // with mul_en high for LAT edges; before that it shows a junk pattern.
  int           stab = 0;
  logic         p_en = 1'b0;
  logic [W-1:0] p_a = '0, p_b = '0;
  always @(negedge clk) begin
    if (!mul_en || !p_en || mul_a != p_a || mul_b != p_b) stab = 0;
    else if (stab < 63) stab = stab + 1;
    p_en = mul_en; p_a = mul_a; p_b = mul_b;
  end

  int ia, ib, ip;
  always_comb begin
    ia = int'($signed(mul_a));
    ib = int'($signed(mul_b));
    ip = ia * ib;
    mul_p = (stab >= LAT) ? ip[PW-1:0] : 11'h2AA;
  end

  // ---------------- checking infrastructure ----------------
  int tests = 0, fails = 0, tick = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", nm, act, exp, tick);
    end
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    r = int'($signed(a)) * int'($signed(b));
    return r[PW-1:0];
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference state: one outstanding operation, its age in cycles since grant.
  bit            m_act, rel_pend;
  int            m_age, m_own, m_ptr;
  logic [W-1:0]  m_a, m_b;
  logic [PW-1:0] m_exp;
  int            last_gnt, last_rv;
  int            gnt_log[$];
  int            gnt_tick[$];

  task automatic model_reset();
    m_act = 0; rel_pend = 0; m_age = 0; m_own = 0; m_ptr = 0;
  endtask

  // Evaluated once per cycle at the falling edge.
  task automatic model_check();
    logic [N-1:0] e_rdy, e_rv;
    int g;
    last_gnt = -1; last_rv = -1;
    if (rel_pend) begin m_act = 0; rel_pend = 0; end
    if (m_act) m_age++;
    e_rdy = '0; e_rv = '0; g = -1;
    if (!m_act) begin
      g = rr_pick(req_valid, m_ptr);
      if (g >= 0) e_rdy[g] = 1'b1;
    end
    // Result shows up on the 8th edge after the accept edge, i.e. it is first
    // visible LAT+2 falling edges after the grant was seen.
    if (m_act && m_age >= LAT + 2) e_rv[m_own] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("busy", 32'(busy), 32'(m_act));
    chk("mul_en", 32'(mul_en), 32'(m_act && m_age <= LAT + 1));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    if (m_act) begin
      chk("mul_a_hold", 32'(mul_a), 32'(m_a));
      chk("mul_b_hold", 32'(mul_b), 32'(m_b));
    end
    if (e_rv != '0) begin
      chk("rsp_p", 32'(rsp_p), 32'(m_exp));
      last_rv = m_own;
      if (rsp_ready[m_own]) rel_pend = 1;
    end
    if (g >= 0) begin
      m_act = 1; m_age = 0; m_own = g;
      m_a = req_a[g]; m_b = req_b[g];
      m_exp = ref_prod(req_a[g], req_b[g]);
      m_ptr = (g + 1) % N;
      last_gnt = g;
      gnt_log.push_back(g);
      gnt_tick.push_back(tick);
    end
  endtask

  // One clock: check at the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    tick++;
    if (mon_on) model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i, output int n);
    n = 0;
    do begin step(); n++; end while (last_gnt != i && n < 60);
    chk($sformatf("grant_%0d", i), 32'(last_gnt), 32'(i));
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rv(input int i);
    int n;
    n = 0;
    do begin step(); n++; end while (last_rv != i && n < 60);
    chk($sformatf("rsp_seen_%0d", i), 32'(last_rv), 32'(i));
  endtask

  task automatic ack(input int i);
    rsp_ready[i] = 1'b1;
    step();
    rsp_ready[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_mul_en"},    32'(mul_en), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_mul_a"},     32'(mul_a), 0);
    chk({tag, "_mul_b"},     32'(mul_b), 0);
    chk({tag, "_rsp_p"},     32'(rsp_p), 0);
  endtask

  typedef struct {
    int            idx;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, t0, s;
    logic [PW-1:0] hold_p;

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    mon_on = 1'b1;
    step();

    // ---- directed single operations ----
    tbl[0] = '{0, 6'h3D, 6'h05, 11'h7F1};  // -3 * 5 = -15
    tbl[1] = '{1, 6'h20, 6'h20, 11'h400};  // -32 * -32 = 1024
    tbl[2] = '{2, 6'h1F, 6'h20, 11'h420};  // 31 * -32 = -992
    tbl[3] = '{3, 6'h00, 6'h3F, 11'h000};  // 0 * -1
    tbl[4] = '{0, 6'h1F, 6'h1F, 11'h3C1};  // 31 * 31 = 961
    tbl[5] = '{2, 6'h3F, 6'h3F, 11'h001};  // -1 * -1
    foreach (tbl[k]) begin
      req_a[tbl[k].idx] = tbl[k].a;
      req_b[tbl[k].idx] = tbl[k].b;
      req_valid[tbl[k].idx] = 1'b1;
      wait_gnt(tbl[k].idx, n);
      chk("tbl_grant_same_cycle", 32'(n), 1);
      t0 = tick;
      chk("tbl_mul_a", 32'(mul_a), 32'(tbl[k].a));
      chk("tbl_mul_b", 32'(mul_b), 32'(tbl[k].b));
      wait_rv(tbl[k].idx);
      chk("tbl_latency", 32'(tick - t0), LAT + 2);
      chk("tbl_rsp_p", 32'(rsp_p), 32'(tbl[k].p));
      ack(tbl[k].idx);
    end

    // ---- fairness: serve 0, then 0 and 2 together -> 2 first ----
    req_a[0] = 6'h02; req_b[0] = 6'h03; req_valid[0] = 1'b1;
    wait_gnt(0, n); wait_rv(0); ack(0);
    req_a[0] = 6'h04; req_b[0] = 6'h3E; req_valid[0] = 1'b1;
    req_a[2] = 6'h05; req_b[2] = 6'h06; req_valid[2] = 1'b1;
    step();
    chk("fair_first", 32'(last_gnt), 2);
    req_valid[2] = 1'b0;
    wait_rv(2); ack(2);
    wait_gnt(0, n);
    chk("fair_regrant_gap", 32'(n), 1);
    wait_rv(0);
    chk("fair_p0", 32'(rsp_p), 32'(11'h7F8));  // 4 * -2
    ack(0);

    // ---- backpressure: owner 1 stalls, 0 waits, non-owner ready ignored ----
    req_a[1] = 6'h3B; req_b[1] = 6'h07; req_valid[1] = 1'b1;  // -5 * 7
    wait_gnt(1, n);
    req_a[0] = 6'h09; req_b[0] = 6'h3D; req_valid[0] = 1'b1;  // 9 * -3
    wait_rv(1);
    hold_p = rsp_p;
    rsp_ready = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
      chk("bp_rsp_p", 32'(rsp_p), 32'(hold_p));
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    chk("bp_value", 32'(hold_p), 32'(11'h7DD));  // -35
    rsp_ready = '0;
    ack(1);
    wait_gnt(0, n);
    chk("bp_regrant_gap", 32'(n), 1);
    wait_rv(0);
    chk("bp_p0", 32'(rsp_p), 32'(11'h7E5));  // -27
    ack(0);

    // ---- reset while BUSY with cnt=3 ----
    req_a[2] = 6'h11; req_b[2] = 6'h13; req_valid[2] = 1'b1;
    wait_gnt(2, n);
    repeat (3) step();
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    mon_on = 1'b1;
    repeat (12) step();  // a stale response would trip the reference here
    req_a[3] = 6'h3C; req_b[3] = 6'h0B; req_valid[3] = 1'b1;  // -4 * 11
    wait_gnt(3, n);
    chk("post_rst_grant_gap", 32'(n), 1);
    wait_rv(3);
    chk("post_rst_p", 32'(rsp_p), 32'(11'h7D4));  // -44
    ack(3);

    // ---- contention: pointer is back at 0, all four at once ----
    s = gnt_log.size();
    rsp_ready = '1;
    for (int k = 0; k < N; k++) begin
      req_a[k] = W'(k + 1); req_b[k] = W'(6'h3F - k);
    end
    req_valid = '1;
    n = 0;
    while (gnt_log.size() < s + N && n < 100) begin
      step(); n++;
      if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
    end
    chk("cont_grants", 32'(gnt_log.size() - s), N);
    for (int k = 0; k < N && s + k < gnt_log.size(); k++) begin
      chk("cont_order", 32'(gnt_log[s + k]), 32'(k));
      if (k > 0) chk("cont_spacing", 32'(gnt_tick[s + k] - gnt_tick[s + k - 1]), LAT + 3);
    end
    repeat (12) step();
    rsp_ready = '0;

    // ---- random traffic against the reference ----
    for (int c = 0; c < 1500; c++) begin
      step();
      if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 3))
            0:       req_a[i] = 6'h20;
            1:       req_a[i] = 6'h1F;
            default: req_a[i] = W'($urandom_range(0, 63));
          endcase
          req_b[i] = ($urandom_range(0, 3) == 0) ? 6'h20 : W'($urandom_range(0, 63));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;  // legal withdrawal before grant
        end
      end
      rsp_ready = N'($urandom_range(0, 15));
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (20) step();
    chk("final_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute backstop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
